ultrasonic_scan_scheduler: RTL and testbench
============================================

// Module: ultrasonic_scan_scheduler
// PURPOSE
//  Round-robin scheduler that shares one ping/measure engine between up to N HC-SR04-style
//  ultrasonic sensors on GPIO. Per slot: fires the selected sensor's trigger, times its echo
//  pulse in CLOCK_50 cycles, enforces a timeout and emits one tagged result.
//  Sits between the GPIO header and the Binary2BCD/seven-segment display path.
// PARAMETERS
//  N_SENSORS      4        number of sensors served (1..8)
//  CNT_W          22       width of the echo counter and the result
//  TRIG_CYCLES    500      trigger high time (10 us at 50 MHz)
//  TIMEOUT_CYCLES 1900000  max cycles from trigger fall to echo fall (38 ms)
//  HOLDOFF_CYCLES 500000   quiet gap after each slot before the next trigger (10 ms)
// PORTS
//  CLOCK_50     in   1            system clock, 50 MHz
//  reset        in   1            synchronous, active-high
//  enable       in   1            1 = scanning runs
//  sensor_mask  in   N_SENSORS    bit i = 1 -> sensor i is in the rotation
//  trig         out  N_SENSORS    trigger outputs, at most one bit high at any time
//  echo         in   N_SENSORS    raw echo inputs, asynchronous
//  result       out  CNT_W        echo width (raw cycles, or cm when CM_CONVERT_EN)
//  result_id    out  clog2(N)     index of the sensor that produced result
//  result_valid out  1            one-cycle strobe; result/result_id/timeout valid
//  timeout      out  1            1 = the slot timed out (qualified by result_valid)
//  busy         out  1            1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset: trig=0, result=0, result_id=0, result_valid=0, timeout=0, busy=0.
//    FSM goes to IDLE and the rotation pointer to 0. Reset mid-slot aborts it and drops trig
//    on the next edge. No result is issued for an aborted slot.
//  - echo passes through a 2-flop synchronizer per bit. Every echo timing below refers to the
//    synced value, so there is a fixed 2-cycle skew that is not compensated.
//  - Selection: from IDLE with enable=1, pick the next set mask bit at or after ptr,
//    wrapping. If mask=0, stay in IDLE with trig=0. The mask is sampled only at selection.
//  - FSM states:
//    IDLE -> TRIG: trig[sel]=1 for exactly TRIG_CYCLES cycles.
//    TRIG -> ARM: clear the timeout counter (tcnt).
//    ARM: if echo_s is high on entry (stale), wait for it to go low first.
//      A 0->1 edge goes to MEASURE.
//    MEASURE: ecnt increments each cycle echo_s=1. Echo fall ends the slot -> RESULT.
//    tcnt runs through ARM and MEASURE. tcnt==TIMEOUT_CYCLES-1 in either state ends the slot
//      with timeout=1 and result=TIMEOUT_CYCLES, saturated.
//    RESULT: result_valid=1 for one cycle. ptr = sel+1 mod N. Then HOLDOFF.
//    HOLDOFF: count HOLDOFF_CYCLES, then IDLE.
//  - ecnt never wraps. It is saturated at 2^CNT_W-1; TIMEOUT_CYCLES < 2^CNT_W is required.
//  - Dropping enable mid-slot: the current slot, including holdoff, completes. The FSM then
//    parks in IDLE.
//  - Latency: echo fall (raw pin) to result_valid is 4 cycles in raw mode.
//  - result/result_id/timeout hold their value until the next result_valid.
// CONFIGURATION
//  - `define ULTRASONIC_CM_CONVERT_EN: RESULT first runs a sequential restoring divider,
//    ecnt / 2900 (50 MHz * 58 us/cm). It takes CNT_W cycles, and result_valid is delayed by
//    those CNT_W cycles. A timeout reports result=9999 with timeout=1.
//  - Macro undefined: result = raw ecnt and no divider logic is built.
// TESTING
//  (sim parameters: N=4, TRIG=10, TIMEOUT=1000, HOLDOFF=50)
//  - reset held 3 cycles while mid-MEASURE -> trig=0, no result_valid, busy=0, ptr=0.
//  - mask=4'b0101, echo[0] high 200 cycles -> trig[0] high 10 cycles.
//    Then result=200, id=0, timeout=0. The next trigger is trig[2].
//  - mask=4'b0010, echo never rises -> result_valid 1000 cycles after trig fall.
//    result=1000, timeout=1, id=1.
//  - echo[3] held high before trigger, then low 5 cycles, then high 300 -> result=300.
//  - mask=0, enable=1 for 5000 cycles -> trig never asserts, busy=0.
//  - CM build, TIMEOUT=2000000, echo high 58000 cycles -> result=20, CNT_W cycles later than
//    the raw build.
//    Timeout case -> result=9999.

Source files
------------

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin trigger/echo timing engine shared by up to 8 ultrasonic sensors.
// Define ULTRASONIC_CM_CONVERT_EN to report centimetres through a serial divider.
module ultrasonic_scan_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int HOLDOFF_CYCLES = 500000,
  localparam int ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  output logic [N_SENSORS-1:0] trig,
  input  logic [N_SENSORS-1:0] echo,
  output logic [CNT_W-1:0]     result,
  output logic [ID_W-1:0]      result_id,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam int M1   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int M2   = (M1 > HOLDOFF_CYCLES) ? M1 : HOLDOFF_CYCLES;
  localparam int MAXC = (M2 > CNT_W) ? M2 : CNT_W;
  localparam int TW   = $clog2(MAXC + 1);

`ifdef ULTRASONIC_CM_CONVERT_EN
  localparam logic [CNT_W-1:0] TO_RES = CNT_W'(9999);
  localparam logic [CNT_W:0]   DIVSR  = (CNT_W+1)'(2900);
`else
  localparam logic [CNT_W-1:0] TO_RES = CNT_W'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_ARM, S_MEAS, S_DIV, S_RES, S_HOLD
  } state_t;

  state_t state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      sel_q, sel_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     ecnt_q, ecnt_d;
  logic [N_SENSORS-1:0] sync1_q, sync2_q;
  logic                 prev_q;
  logic [N_SENSORS-1:0] trig_q, trig_d;
  logic [CNT_W-1:0]     result_q, result_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 valid_q, valid_d;
  logic                 tout_q, tout_d;

`ifdef ULTRASONIC_CM_CONVERT_EN
  logic [CNT_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W:0]   rs;
`endif

  logic            echo_s;
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] nxt;
  logic            to_hit;
  logic            end_slot;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              k
  );
    int s;
    s = int'(base) + k;
    if (s >= N_SENSORS) s = s - N_SENSORS;
    return ID_W'(s);
  endfunction

  assign echo_s = sync2_q[sel_q];
  assign to_hit = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign nxt    = (sel_q == ID_W'(N_SENSORS - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      if (!found && sensor_mask[wrap_idx(ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    result_d = result_q;
    id_d     = id_q;
    tout_d   = tout_q;
    valid_d  = 1'b0;
    end_slot = 1'b0;
`ifdef ULTRASONIC_CM_CONVERT_EN
    quo_d    = quo_q;
    rem_d    = rem_q;
    rs       = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (cnt_q == TW'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          ecnt_d  = '0;
          state_d = S_ARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ARM: begin
        // A stale high echo never looks like a rising edge.
        if (to_hit) begin
          end_slot = 1'b1;
          result_d = TO_RES;
          tout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (echo_s && !prev_q) begin
            ecnt_d  = CNT_W'(1);
            state_d = S_MEAS;
          end
        end
      end
      S_MEAS: begin
        if (to_hit) begin
          end_slot = 1'b1;
          result_d = TO_RES;
          tout_d   = 1'b1;
        end else if (!echo_s) begin
`ifdef ULTRASONIC_CM_CONVERT_EN
          quo_d   = ecnt_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
`else
          state_d = S_RES;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
        end
      end
      S_DIV: begin
`ifdef ULTRASONIC_CM_CONVERT_EN
        rs = {rem_q, quo_q[CNT_W-1]};
        if (rs >= DIVSR) begin
          rem_d = CNT_W'(rs - DIVSR);
          quo_d = {quo_q[CNT_W-2:0], 1'b1};
        end else begin
          rem_d = CNT_W'(rs);
          quo_d = {quo_q[CNT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TW'(CNT_W - 1)) state_d = S_RES;
`else
        state_d = S_RES;
`endif
      end
      S_RES: begin
        end_slot = 1'b1;
        tout_d   = 1'b0;
`ifdef ULTRASONIC_CM_CONVERT_EN
        result_d = quo_q;
`else
        result_d = ecnt_q;
`endif
      end
      S_HOLD: begin
        if (cnt_q == TW'(HOLDOFF_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (end_slot) begin
      valid_d = 1'b1;
      id_d    = sel_q;
      ptr_d   = nxt;
      cnt_d   = '0;
      state_d = S_HOLD;
    end
  end

  always_comb begin
    trig_d = '0;
    if (state_d == S_TRIG) trig_d[sel_d] = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= 1'b0;
      trig_q   <= '0;
      result_q <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
`ifdef ULTRASONIC_CM_CONVERT_EN
      quo_q    <= '0;
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      sync1_q  <= echo;
      sync2_q  <= sync1_q;
      prev_q   <= echo_s;
      trig_q   <= trig_d;
      result_q <= result_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
`ifdef ULTRASONIC_CM_CONVERT_EN
      quo_q    <= quo_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign trig         = trig_q;
  assign result       = result_q;
  assign result_id    = id_q;
  assign result_valid = valid_q;
  assign timeout      = tout_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Randomized bench for ultrasonic_scan_scheduler against a slot-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ultrasonic_scan_scheduler;

  localparam int N     = 4;
  localparam int CW    = 22;
  localparam int TRIGC = 10;
  localparam int TO    = 1000;
  localparam int HO    = 50;
`ifdef ULTRASONIC_CM_CONVERT_EN
  localparam int LAT   = 4 + CW;
  localparam int TORES = 9999;
`else
  localparam int LAT   = 4;
  localparam int TORES = TO;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  mask;
  logic [N-1:0]  trig;
  logic [N-1:0]  echo;
  logic [CW-1:0] result;
  logic [1:0]    rid;
  logic          rv;
  logic          tmo;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  always #5 clk = ~clk;

  ultrasonic_scan_scheduler #(
    .N_SENSORS(N), .CNT_W(CW), .TRIG_CYCLES(TRIGC),
    .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable),
    .sensor_mask(mask), .trig(trig), .echo(echo),
    .result(result), .result_id(rid), .result_valid(rv),
    .timeout(tmo), .busy(busy)
  );

  function automatic int exp_sel(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (((m >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
    return -1;
  endfunction

  function automatic int exp_res(input int w);
`ifdef ULTRASONIC_CM_CONVERT_EN
    return w / 2900;
`else
    return w;
`endif
  endfunction

  task automatic wait_trig(output int idx, output int width,
                           output logic [N-1:0] tv);
    idx = -1; width = 0; tv = '0;
    for (int i = 0; i < 400 && trig == '0; i++) @(negedge clk);
    tv = trig;
    for (int b = 0; b < N; b++) if (tv[b]) idx = b;
    while (trig != '0 && width < 1000) begin
      width++;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output int lat);
    bit got;
    got = 0; lat = 0;
    while (!got && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (rv) got = 1;
    end
    if (!got) lat = -1;
  endtask

  task automatic echo_slot(input int s, input int d, input int w,
                           output int lat);
    repeat (d) @(negedge clk);
    echo[s] = 1'b1;
    repeat (w) @(negedge clk);
    echo[s] = 1'b0;
    wait_valid(lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mask = '0; echo = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (trig !== '0 || rv !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl trig=%b rv=%b busy=%b want 0", trig, rv, busy);
    end
    checks++;
    if (result !== '0 || rid !== '0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_res result=%0d id=%0d tmo=%b want 0", result, rid, tmo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int idx, wd, lat, es;
    logic [N-1:0] tv;
    mask = 4'b0101; enable = 1'b1;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    checks++;
    if (tv !== 4'b0001 || wd != TRIGC) begin
      errors++;
      $display("FAIL basic_trig trig=%b width=%0d want 0001/%0d", tv, wd, TRIGC);
    end
    echo_slot(0, 5, 200, lat);
    checks++;
    if (lat != LAT || result !== CW'(exp_res(200)) || rid !== 2'(es) || tmo !== 1'b0) begin
      errors++;
      $display("FAIL basic_res lat=%0d res=%0d id=%0d tmo=%b want %0d/%0d/%0d/0",
               lat, result, rid, tmo, LAT, exp_res(200), es);
    end
    mptr = (es + 1) % N;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    checks++;
    if (tv !== 4'b0100 || idx != es) begin
      errors++;
      $display("FAIL basic_next trig=%b want 0100", tv);
    end
    echo_slot(2, 0, 50, lat);
    checks++;
    if (result !== CW'(exp_res(50)) || rid !== 2'd2) begin
      errors++;
      $display("FAIL basic_res2 res=%0d id=%0d want %0d/2", result, rid, exp_res(50));
    end
    mptr = (es + 1) % N;
  endtask

  task automatic test_random();
    int idx, wd, lat, es, d, w;
    logic [N-1:0] tv;
    for (int it = 0; it < 8; it++) begin
      mask = N'($urandom_range(1, 15));
      es = exp_sel(mask, mptr);
      wait_trig(idx, wd, tv);
      checks++;
      if (idx != es || !$onehot(tv) || wd != TRIGC) begin
        errors++;
        $display("FAIL rand_trig it=%0d trig=%b width=%0d want idx %0d", it, tv, wd, es);
      end
      d = $urandom_range(0, 100);
      w = $urandom_range(1, 600);
      echo_slot(es, d, w, lat);
      checks++;
      if (lat != LAT || result !== CW'(exp_res(w)) || rid !== 2'(es) || tmo !== 1'b0) begin
        errors++;
        $display("FAIL rand_res it=%0d lat=%0d res=%0d id=%0d tmo=%b want %0d/%0d/%0d/0",
                 it, lat, result, rid, tmo, LAT, exp_res(w), es);
      end
      mptr = (es + 1) % N;
    end
  endtask

  task automatic test_timeout();
    int idx, wd, lat, es;
    logic [N-1:0] tv;
    mask = 4'b0010;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    wait_valid(lat);
    checks++;
    if (lat != TO) begin
      errors++;
      $display("FAIL timeout_lat got %0d want %0d", lat, TO);
    end
    checks++;
    if (result !== CW'(TORES) || tmo !== 1'b1 || rid !== 2'(es)) begin
      errors++;
      $display("FAIL timeout_res res=%0d tmo=%b id=%0d want %0d/1/%0d",
               result, tmo, rid, TORES, es);
    end
    mptr = (es + 1) % N;
  endtask

  task automatic test_stale();
    int idx, wd, lat, es;
    logic [N-1:0] tv;
    mask = 4'b1000;
    echo[3] = 1'b1;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    checks++;
    if (idx != es) begin
      errors++;
      $display("FAIL stale_trig idx=%0d want %0d", idx, es);
    end
    repeat (3) @(negedge clk);
    echo[3] = 1'b0;
    repeat (5) @(negedge clk);
    echo_slot(3, 0, 300, lat);
    checks++;
    if (result !== CW'(exp_res(300)) || tmo !== 1'b0 || lat != LAT) begin
      errors++;
      $display("FAIL stale_res res=%0d tmo=%b lat=%0d want %0d/0/%0d",
               result, tmo, lat, exp_res(300), LAT);
    end
    mptr = (es + 1) % N;
  endtask

  task automatic test_enable_drop();
    int idx, wd, lat, es, bad;
    logic [N-1:0] tv;
    mask = 4'b0100;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    echo[2] = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (80) @(negedge clk);
    echo[2] = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != LAT || result !== CW'(exp_res(100)) || rid !== 2'(es)) begin
      errors++;
      $display("FAIL endrop_res lat=%0d res=%0d id=%0d want %0d/%0d/%0d",
               lat, result, rid, LAT, exp_res(100), es);
    end
    mptr = (es + 1) % N;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL endrop_hold busy=%b want 1", busy);
    end
    repeat (HO + 5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (trig !== '0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL endrop_park active cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_mask_zero();
    int bad;
    mask = '0;
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (trig !== '0 || busy !== 1'b0 || rv !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mask_zero active cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int idx, wd, lat, es, bad;
    logic [N-1:0] tv;
    mask = 4'b0010;
    es = exp_sel(mask, mptr);
    wait_trig(idx, wd, tv);
    checks++;
    if (idx != es) begin
      errors++;
      $display("FAIL rmid_trig idx=%0d want %0d", idx, es);
    end
    echo[1] = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (trig !== '0 || rv !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || result !== '0 || rid !== '0) begin
      errors++;
      $display("FAIL rmid_reset bad=%0d res=%0d id=%0d want 0/0/0", bad, result, rid);
    end
    echo = '0;
    mask = 4'b1111;
    reset = 1'b0;
    mptr = 0;
    es = exp_sel(mask, mptr);
    bad = 0;
    for (int i = 0; i < 400 && trig == '0; i++) begin
      if (rv !== 1'b0) bad++;
      @(negedge clk);
    end
    wait_trig(idx, wd, tv);
    checks++;
    if (idx != es || bad != 0) begin
      errors++;
      $display("FAIL rmid_ptr idx=%0d stray_valid=%0d want %0d/0", idx, bad, es);
    end
    echo_slot(es, 2, 30, lat);
    checks++;
    if (result !== CW'(exp_res(30)) || rid !== 2'(es)) begin
      errors++;
      $display("FAIL rmid_res res=%0d id=%0d want %0d/%0d", result, rid, exp_res(30), es);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mask = '0; echo = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_timeout();
    test_stale();
    test_enable_drop();
    test_mask_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
